// File: rtl/rf_pkg.sv
// Shared types and helpers for the multi-port register file.
package rf_pkg;

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_t;

    function automatic int unsigned slice_lo(input int unsigned port, input int unsigned width);
        return port * width;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending bits for hazard detection plus per-read-port ready lookup.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NREG = 32,
    parameter int NRD  = 2,
    parameter int AW   = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set_en,
    input  logic [AW-1:0]     set_addr,
    input  logic              clr_en,
    input  logic [AW-1:0]     clr_addr,
    input  logic              wipe_en,
    input  logic [AW-1:0]     wipe_addr,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD-1:0]    free
);

    logic [NREG-1:0] pend;

    // Clear-engine wipe beats everything; a reservation beats a same-cycle write
    // because the reserving instruction is the newer producer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (wipe_en && wipe_addr == AW'(r))
                    pend[r] <= 1'b0;
                else if (set_en && set_addr == AW'(r))
                    pend[r] <= 1'b1;
                else if (clr_en && clr_addr == AW'(r))
                    pend[r] <= 1'b0;
            end
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_port
        logic [AW-1:0] addr;
        assign addr    = rd_addr[slice_lo(i, AW) +: AW];
        assign free[i] = (addr == '0) || !pend[addr];
    end

endmodule

// File: rtl/rf_multiport.sv
// Multi-read-port register file with pending scoreboard and sequenced clear.
// Optional same-cycle write-to-read bypass is enabled by defining RF_BYPASS_EN.
module rf_multiport
    import rf_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRD  = 2,
    parameter int AW   = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_rdy,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                rsv_en,
    input  logic [AW-1:0]       rsv_addr,
    input  logic                clr_req,
    output logic                busy,
    output logic                clr_done
);

    rf_state_t       state, state_nx;
    logic [AW-1:0]   idx, idx_nx;
    logic [XLEN-1:0] regs [NREG];
    logic [NRD-1:0]  sb_free;
    logic            wr_fire;
    logic            rsv_fire;

    assign wr_fire  = wr_en  && !busy && (wr_addr  != '0);
    assign rsv_fire = rsv_en && !busy && (rsv_addr != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RF_IDLE;
            idx   <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
        end
    end

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        busy     = 1'b0;
        clr_done = 1'b0;
        case (state)
            RF_IDLE: begin
                if (clr_req) begin
                    state_nx = RF_CLEAR;
                    idx_nx   = AW'(1);
                end
            end
            RF_CLEAR: begin
                busy   = 1'b1;
                idx_nx = idx + AW'(1);
                if (idx == AW'(NREG - 1)) begin
                    clr_done = 1'b1;
                    state_nx = RF_IDLE;
                end
            end
            default: state_nx = RF_IDLE;
        endcase
    end

    // Writes and the clear engine never coincide: wr_fire is gated by busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++)
                regs[r] <= '0;
        end else if (busy) begin
            regs[idx] <= '0;
        end else if (wr_fire) begin
            regs[wr_addr] <= wr_data;
        end
    end

    rf_scoreboard #(
        .NREG (NREG),
        .NRD  (NRD),
        .AW   (AW)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .set_en    (rsv_fire),
        .set_addr  (rsv_addr),
        .clr_en    (wr_fire),
        .clr_addr  (wr_addr),
        .wipe_en   (busy),
        .wipe_addr (idx),
        .rd_addr   (rd_addr),
        .free      (sb_free)
    );

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] arr_val;
        assign addr    = rd_addr[slice_lo(i, AW) +: AW];
        assign arr_val = (addr == '0) ? {XLEN{1'b0}} : regs[addr];
`ifdef RF_BYPASS_EN
        logic hit;
        logic rsv_same;
        assign hit      = wr_fire && (addr == wr_addr);
        assign rsv_same = rsv_fire && (rsv_addr == wr_addr);
        assign rd_data[slice_lo(i, XLEN) +: XLEN] = hit ? wr_data : arr_val;
        assign rd_rdy[i] = !busy && (sb_free[i] || (hit && !rsv_same));
`else
        assign rd_data[slice_lo(i, XLEN) +: XLEN] = arr_val;
        assign rd_rdy[i] = !busy && sb_free[i];
`endif
    end

endmodule

// File: doc/rf_multiport.md
# rf_multiport

Parametrised multi-read-port integer register file for the pipelined core. It replaces the fixed 32×32 two-read-port file and adds three things: write-to-read bypass, a per-register pending scoreboard for hazard detection, and a sequenced clear engine. It sits between decode (reads, reservations) and writeback (writes).

## Interface
Parameters:
- XLEN, 32, data width in bits
- NREG, 32, number of registers (power of two, ≥4)
- NRD, 2, number of read ports
- AW, $clog2(NREG), register address width (derived, not overridden)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- rd_addr  in  NRD*AW  read addresses; port i in bits [i*AW +: AW]
- rd_data  out  NRD*XLEN  read data per port
- rd_rdy  out  NRD  1 = port i operand valid (not pending, not clearing)
- wr_en  in  1  write strobe
- wr_addr  in  AW  write address
- wr_data  in  XLEN  write data
- rsv_en  in  1  reserve destination (mark pending)
- rsv_addr  in  AW  register to reserve
- clr_req  in  1  start clear sequence (level-sampled)
- busy  out  1  clear sequence in progress
- clr_done  out  1  one-cycle pulse on the last clear cycle

## Operation
- Register 0 is hardwired zero: reads return 0, rd_rdy=1; writes and reservations to 0 are dropped.
- Reads are combinational from the array (plus bypass, see Configuration).
- Write: on rising edge with wr_en=1, busy=0 and wr_addr≠0, reg[wr_addr]←wr_data and pend[wr_addr]←0.
- Reserve: on rising edge with rsv_en=1, busy=0 and rsv_addr≠0, pend[rsv_addr]←1.
- Same-address write and reserve in the same cycle: data is written and pend stays 1 (the newer producer wins).
- rd_rdy[i] = !busy && (rd_addr_i==0 || !pend[rd_addr_i]) (bypass also sets it; see Configuration).
- Clear FSM states are IDLE and CLEAR.
  - IDLE→CLEAR when clr_req=1; idx←1.
  - In CLEAR, each cycle: reg[idx]←0, pend[idx]←0, idx←idx+1.
  - CLEAR→IDLE after idx=NREG-1 is cleared; clr_done=1 in that cycle.
  - clr_req is ignored while in CLEAR.
  - wr_en and rsv_en are ignored while busy=1.
- Reset: all registers, all pend bits and idx go to 0, FSM goes to IDLE. Outputs after reset: busy=0, clr_done=0. rd_data and rd_rdy follow their combinational rules (all data 0, all rdy 1).
- Reset asserted mid-CLEAR aborts the sequence immediately. No clr_done is produced.

## Timing
- Read latency: 0 cycles, combinational.
- A write is visible to reads in the next cycle (or the same cycle with bypass).
- A reservation drops rd_rdy in the next cycle.
- busy rises in the cycle after clr_req is sampled and stays high for exactly NREG-1 cycles.
- clr_done coincides with the last busy cycle.
- The first write is accepted in the cycle after busy falls.

## Configuration
- RF_BYPASS_EN defined:
  - When wr_en=1, busy=0, wr_addr≠0 and rd_addr_i==wr_addr, then rd_data_i=wr_data and rd_rdy[i]=1 in that same cycle.
  - Because of the newer-producer rule, rd_rdy stays 0 if rsv_en targets the same address in that cycle.
- RF_BYPASS_EN undefined:
  - Reads return the pre-edge array value.
  - rd_rdy follows the pend bit only.

## Structure
- Package rf_pkg holds:
  - the FSM state typedef (RF_IDLE, RF_CLEAR)
  - the helper function for the read-port slice index
- Sub-module rf_scoreboard holds:
  - the NREG-bit pend vector
  - the set/clear priority logic
  - the per-port ready lookup
- The data array and clear FSM live in the top module.

## Test plan
- Reset, then read ports 0 and 1 at addresses 5 and 0: rd_data=0, rd_rdy=2'b11.
- Write 0xDEADBEEF to r7, then read r7 next cycle: 0xDEADBEEF. Write to r0, then read r0: 0.
- Reserve r3 → rd_rdy for r3 goes 0. Write r3=0x12 four cycles later → rd_rdy=1 next cycle (same cycle with RF_BYPASS_EN), data 0x12. Write and reserve r3 together → rd_rdy stays 0.
- With RF_BYPASS_EN: write r9=0x55 while reading r9 → rd_data=0x55 in the same cycle. Without the macro: the old value that cycle, 0x55 the next.
- Fill all registers, pulse clr_req: busy high for NREG-1 cycles, clr_done on the last one, writes ignored during busy. All reads return 0 with rd_rdy=1 afterwards.
- Pulse clr_req, then assert rst_n=0 after 5 cycles: busy drops immediately, no clr_done, all registers read 0.
